nn_host_line_reader: RTL and testbench

//  Host-memory read engine for the neural-net AFU; the read-side counterpart of the c1 result-write path.
//  On start, issues NUM_LINES c0 read-line requests from BASE_ADDR upward; buffers responses (out of order).

---
 rtl/nn_host_rd_pkg.sv | 26 ++
 rtl/nn_rsp_fifo.sv | 53 +++++
 rtl/nn_host_line_reader.sv | 162 ++++++++++++++++
 tb/tb_nn_host_line_reader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_host_rd_pkg.sv
// rtl/nn_host_rd_pkg.sv - shared types for the host line reader
// Purpose: FSM state encoding and response-entry types for nn_host_line_reader
//          and its response FIFO.
// Contents: t_nn_rd_state, t_line_idx, t_rsp_entry, default widths.
package nn_host_rd_pkg;

  localparam int NN_LINE_CNT_W = 16;
  localparam int NN_DATA_W     = 512;
  localparam int NN_ADDR_W     = 42;
  localparam int NN_MDATA_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } t_nn_rd_state;

  typedef logic [NN_LINE_CNT_W-1:0] t_line_idx;

  typedef struct packed {
    t_line_idx            idx;
    logic [NN_DATA_W-1:0] data;
  } t_rsp_entry;

endpackage

// File: rtl/nn_rsp_fifo.sv
// rtl/nn_rsp_fifo.sv - synchronous response FIFO for the host line reader
// Purpose: buffers read responses in arrival order; no write-to-read bypass,
//          so a pushed entry is visible on pop_data the cycle after the push.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, push_data   write request and entry
//   pop               advance read pointer (ignored when empty)
//   pop_data          head entry (valid while !empty)
//   empty, full       occupancy flags
module nn_rsp_fifo
  import nn_host_rd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = NN_LINE_CNT_W + NN_DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_data = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_q[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push && !full) wr_q <= wr_q + 1'b1;
      if (pop && !empty) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/nn_host_line_reader.sv
// rtl/nn_host_line_reader.sv - credit-limited c0 host read engine with streaming output
// Purpose: on start, issues num_lines c0 read requests from base_addr upward,
//          buffers responses in arrival order and streams them out with the
//          line index as tag; pulses done once every line is handed off.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   start, base_addr, num_lines   job launch (sampled only in IDLE)
//   c0TxAlmFull                   request channel back-pressure
//   c0_req_valid/addr/mdata       registered read request, mdata = line index
//   c0_rsp_valid/mdata/data       read response, always accepted
//   out_valid/ready/idx/data      output stream
//   busy, done                    job status
// Option: NN_LINE_READER_STATS_EN adds stat_almfull_cycles,
//   stat_credit_stall_cycles and stat_stray_rsp (saturating).
module nn_host_line_reader
  import nn_host_rd_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 16,
  parameter int LINE_CNT_W      = 16,
  parameter int DATA_W          = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NN_ADDR_W-1:0]  base_addr,
  input  logic [LINE_CNT_W-1:0] num_lines,
  input  logic                  c0TxAlmFull,
  output logic                  c0_req_valid,
  output logic [NN_ADDR_W-1:0]  c0_req_addr,
  output logic [NN_MDATA_W-1:0] c0_req_mdata,
  input  logic                  c0_rsp_valid,
  input  logic [NN_MDATA_W-1:0] c0_rsp_mdata,
  input  logic [DATA_W-1:0]     c0_rsp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LINE_CNT_W-1:0] out_idx,
  output logic [DATA_W-1:0]     out_data,
  output logic                  busy,
  output logic                  done
`ifdef NN_LINE_READER_STATS_EN
  ,
  output logic [31:0]           stat_almfull_cycles,
  output logic [31:0]           stat_credit_stall_cycles,
  output logic [15:0]           stat_stray_rsp
`endif
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(MAX_OUTSTANDING);

  t_nn_rd_state          state_q, state_d;
  logic [NN_ADDR_W-1:0]  base_q;
  logic [LINE_CNT_W-1:0] num_q, issued_q, delivered_q;
  logic [CW-1:0]         credits_q;
  logic                  req_valid_q, done_q;
  logic [NN_ADDR_W-1:0]  req_addr_q;
  logic [NN_MDATA_W-1:0] req_mdata_q;

  logic fifo_empty, fifo_full, pop, start_acc, issue_fire;

  assign start_acc  = (state_q == ST_IDLE) && start;
  assign issue_fire = (state_q == ST_ISSUE) && !c0TxAlmFull &&
                      (credits_q != '0) && (issued_q < num_q);
  assign out_valid  = !fifo_empty;
  assign pop        = out_valid && out_ready;

  assign busy         = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done         = done_q;
  assign c0_req_valid = req_valid_q;
  assign c0_req_addr  = req_addr_q;
  assign c0_req_mdata = req_mdata_q;

  nn_rsp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (LINE_CNT_W + DATA_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (c0_rsp_valid),
    .push_data ({c0_rsp_mdata[LINE_CNT_W-1:0], c0_rsp_data}),
    .pop       (pop),
    .pop_data  ({out_idx, out_data}),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (num_lines == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (issued_q == num_q) state_d = ST_DRAIN;
      ST_DRAIN: if (delivered_q == num_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      num_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      credits_q   <= CRED_MAX;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_mdata_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      // done trails the DONE state by one cycle, so busy has already dropped.
      done_q      <= (state_q == ST_DONE);
      req_valid_q <= issue_fire;
      if (start_acc) begin
        base_q      <= base_addr;
        num_q       <= num_lines;
        issued_q    <= '0;
        delivered_q <= '0;
      end
      if (issue_fire) begin
        req_addr_q  <= base_q + NN_ADDR_W'(issued_q);
        req_mdata_q <= NN_MDATA_W'(issued_q);
        issued_q    <= issued_q + 1'b1;
      end
      if (pop && busy) delivered_q <= delivered_q + 1'b1;
      // Stray pops in IDLE must not push credits above the FIFO depth.
      if (issue_fire && !pop) begin
        credits_q <= credits_q - 1'b1;
      end else if (!issue_fire && pop && (credits_q != CRED_MAX)) begin
        credits_q <= credits_q + 1'b1;
      end
    end
  end

`ifdef NN_LINE_READER_STATS_EN
  logic [31:0] almfull_q, cstall_q;
  logic [15:0] stray_q;
  logic        issue_pending;

  assign issue_pending            = (state_q == ST_ISSUE) && (issued_q < num_q);
  assign stat_almfull_cycles      = almfull_q;
  assign stat_credit_stall_cycles = cstall_q;
  assign stat_stray_rsp           = stray_q;

  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      almfull_q <= '0;
      cstall_q  <= '0;
      stray_q   <= '0;
    end else begin
      if (issue_pending && c0TxAlmFull && (almfull_q != '1))
        almfull_q <= almfull_q + 1'b1;
      if (issue_pending && !c0TxAlmFull && (credits_q == '0) && (cstall_q != '1))
        cstall_q <= cstall_q + 1'b1;
      if (c0_rsp_valid && (state_q == ST_IDLE) && (stray_q != '1))
        stray_q <= stray_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_nn_host_line_reader.sv
// tb/tb_nn_host_line_reader.sv - scoreboard bench for nn_host_line_reader
module tb_nn_host_line_reader;

  localparam int DW = 512;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset, start, c0TxAlmFull, c0_rsp_valid, out_ready;
  logic [41:0]   base_addr;
  logic [LW-1:0] num_lines;
  logic          c0_req_valid;
  logic [41:0]   c0_req_addr;
  logic [15:0]   c0_req_mdata;
  logic [15:0]   c0_rsp_mdata;
  logic [DW-1:0] c0_rsp_data;
  logic          out_valid;
  logic [LW-1:0] out_idx;
  logic [DW-1:0] out_data;
  logic          busy, done;
`ifdef NN_LINE_READER_STATS_EN
  logic [31:0]   stat_almfull_cycles, stat_credit_stall_cycles;
  logic [15:0]   stat_stray_rsp;
`endif

  always #5 clk = ~clk;

  nn_host_line_reader #(
    .MAX_OUTSTANDING (16),
    .LINE_CNT_W      (LW),
    .DATA_W          (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .num_lines    (num_lines),
    .c0TxAlmFull  (c0TxAlmFull),
    .c0_req_valid (c0_req_valid),
    .c0_req_addr  (c0_req_addr),
    .c0_req_mdata (c0_req_mdata),
    .c0_rsp_valid (c0_rsp_valid),
    .c0_rsp_mdata (c0_rsp_mdata),
    .c0_rsp_data  (c0_rsp_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_idx      (out_idx),
    .out_data     (out_data),
    .busy         (busy),
    .done         (done)
`ifdef NN_LINE_READER_STATS_EN
    ,
    .stat_almfull_cycles      (stat_almfull_cycles),
    .stat_credit_stall_cycles (stat_credit_stall_cycles),
    .stat_stray_rsp           (stat_stray_rsp)
`endif
  );

  int checks = 0;
  int fails  = 0;
  int req_cnt = 0, done_cnt = 0, win_reqs = 0;
  bit auto_rsp = 1'b0;
  bit win = 1'b0;

  logic [57:0]      exp_req[$];
  logic [LW+DW-1:0] exp_out[$];
  logic [15:0]      rsp_q[$];

  function automatic logic [DW-1:0] mk(input logic [15:0] idx);
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = {idx ^ 16'h5A00, 16'(k)};
    return d;
  endfunction

  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [41:0] b, input logic [LW-1:0] n, input bit push_exp);
    logic [41:0] a;
    base_addr = b;
    num_lines = n;
    start     = 1'b1;
    if (push_exp) begin
      for (int i = 0; i < int'(n); i++) begin
        a = b + 42'(i);
        exp_req.push_back({a, 16'(i)});
      end
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string n, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    chk({n, "_done_seen"}, done_cnt - d0, 1);
    repeat (5) tick();
    chk({n, "_done_once"}, done_cnt - d0, 1);
    chk({n, "_req_sb_empty"}, exp_req.size(), 0);
    chk({n, "_out_sb_empty"}, exp_out.size(), 0);
  endtask

  task automatic wait_reqs(input int r0, input int n);
    for (int i = 0; i < 200 && (req_cnt - r0) < n; i++) tick();
    chk("req_wait", (req_cnt - r0) >= n, 1);
  endtask

  // Monitor: compares every request and every handed-off line with the scoreboard.
  always @(negedge clk) begin
    logic [57:0]      er;
    logic [LW+DW-1:0] eo;
    if (!reset) begin
      if (c0_req_valid) begin
        req_cnt++;
        if (win) win_reqs++;
        if (auto_rsp) rsp_q.push_back(c0_req_mdata);
        checks++;
        if (exp_req.size() == 0) begin
          fails++;
          $display("FAIL req_unexpected: got addr %h mdata %0d, required no request",
                   c0_req_addr, c0_req_mdata);
        end else begin
          er = exp_req.pop_front();
          if ({c0_req_addr, c0_req_mdata} !== er) begin
            fails++;
            $display("FAIL req_match: got addr %h mdata %0d, required addr %h mdata %0d",
                     c0_req_addr, c0_req_mdata, er[57:16], er[15:0]);
          end
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_out.size() == 0) begin
          fails++;
          $display("FAIL out_unexpected: got idx %0d, required no output", out_idx);
        end else begin
          eo = exp_out.pop_front();
          if ({out_idx, out_data} !== eo) begin
            fails++;
            $display("FAIL out_match: got idx %0d data[31:0] %h, required idx %0d data[31:0] %h",
                     out_idx, out_data[31:0], eo[LW+DW-1:DW], eo[31:0]);
          end
        end
      end
      if (done) done_cnt++;
    end
  end

  // Responder: one response per cycle from rsp_q; expected output follows arrival order.
  initial begin
    logic [15:0] idx;
    c0_rsp_valid = 1'b0;
    c0_rsp_mdata = '0;
    c0_rsp_data  = '0;
    forever begin
      tick();
      if (rsp_q.size() != 0) begin
        idx          = rsp_q.pop_front();
        c0_rsp_valid = 1'b1;
        c0_rsp_mdata = idx;
        c0_rsp_data  = mk(idx);
        exp_out.push_back({idx, mk(idx)});
      end else begin
        c0_rsp_valid = 1'b0;
      end
    end
  end

  initial begin
    int r0;
    logic [15:0] order [8];
    order = '{16'd3, 16'd0, 16'd7, 16'd1, 16'd2, 16'd6, 16'd5, 16'd4};
    reset = 1'b1; start = 1'b0; c0TxAlmFull = 1'b0; out_ready = 1'b1;
    base_addr = '0; num_lines = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_req_valid", c0_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    tick();
    reset = 1'b0;
    tick();

    // 1: four lines, in-order responses
    auto_rsp = 1'b1;
    r0 = req_cnt;
    do_start(42'h1000, 16'd4, 1'b1);
    chk("t1_busy", busy, 1);
    wait_done("t1", 200);
    chk("t1_reqs", req_cnt - r0, 4);

    // 2: credit limit of 16 with consumer stalled; addresses wrap mod 2^42
    out_ready = 1'b0;
    r0 = req_cnt;
    do_start(42'h3FF_FFFF_FFF0, 16'd40, 1'b1);
    repeat (60) tick();
    chk("t2_stall_reqs", req_cnt - r0, 16);
    chk("t2_out_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_done("t2", 2000);
    chk("t2_reqs", req_cnt - r0, 40);

    // 3: out-of-order responses delivered in arrival order
    auto_rsp = 1'b0;
    r0 = req_cnt;
    do_start(42'h5000, 16'd8, 1'b1);
    wait_reqs(r0, 8);
    for (int i = 0; i < 8; i++) rsp_q.push_back(order[i]);
    wait_done("t3", 300);

    // 4: almost-full held for 20 cycles mid-run
    auto_rsp = 1'b1;
    r0 = req_cnt;
    do_start(42'h8000, 16'd12, 1'b1);
    wait_reqs(r0, 4);
    c0TxAlmFull = 1'b1;
    tick();
    win = 1'b1;
    repeat (19) tick();
    c0TxAlmFull = 1'b0;
    tick();
    win = 1'b0;
    @(negedge clk);
    chk("t4_blocked_reqs", win_reqs, 0);
    chk("t4_resume", c0_req_valid, 1);
`ifdef NN_LINE_READER_STATS_EN
    chk("t4_stat_almfull", stat_almfull_cycles, 20);
`endif
    wait_done("t4", 300);

    // 5: zero-length job, then start while busy
    r0 = req_cnt;
    base_addr = 42'h7700; num_lines = '0; start = 1'b1;
    @(negedge clk);
    chk("t5_done_c0", done, 0);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("t5_done_c1", done, 0);
    tick();
    @(negedge clk);
    chk("t5_done_c2", done, 1);
    tick();
    @(negedge clk);
    chk("t5_done_c3", done, 0);
    chk("t5_no_reqs", req_cnt - r0, 0);
    r0 = req_cnt;
    do_start(42'h9000, 16'd4, 1'b1);
    tick();
    do_start(42'hEEEE, 16'd100, 1'b0);
    wait_done("t5", 300);
    chk("t5_busy_start_reqs", req_cnt - r0, 4);

    // 6: reset mid-run, then a clean job
    auto_rsp = 1'b0;
    r0 = req_cnt;
    do_start(42'hA000, 16'd10, 1'b1);
    wait_reqs(r0, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_req_valid", c0_req_valid, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    exp_req.delete();
    rsp_q.delete();
    tick();
    auto_rsp = 1'b1;
    r0 = req_cnt;
    do_start(42'h2000, 16'd2, 1'b1);
    wait_done("t6", 200);
    chk("t6_reqs", req_cnt - r0, 2);

    // 7: stray response in IDLE is still drained
    rsp_q.push_back(16'h0077);
    repeat (6) tick();
    chk("t7_stray_drained", exp_out.size(), 0);
    chk("t7_idle_out_valid", out_valid, 0);
`ifdef NN_LINE_READER_STATS_EN
    chk("t7_stat_stray", stat_stray_rsp, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
